mram_port_arb: RTL
==================

Name: mram_port_arb

Overview:
- Round-robin arbiter that shares one port of the dual-port position RAM between NUM_REQ requesters, e.g. move generator writers, evaluator readers and the host loader.
- Accepts one read or write per cycle and drives registered address, write-enable and write-data to the RAM port.
- Tracks the RAM's 2-cycle read latency and returns each read's data tagged with the issuing requester's ID.
- Sits between requesters and one port of the position RAM; the other RAM port is unaffected.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- RAM_WIDTH, 64, RAM word width in bits.
- MAX_POSITIONS_LOG2, $clog2(`MAX_POSITIONS), RAM address width.
- RD_LATENCY, 2, RAM read latency in clocks (address sampled to data valid).
- ID_W, $clog2(NUM_REQ), requester ID width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request pending.
- req_wr  in  NUM_REQ  1=write, 0=read.
- req_addr  in  NUM_REQ*MAX_POSITIONS_LOG2  packed addresses; requester i at slice i.
- req_wr_data  in  NUM_REQ*RAM_WIDTH  packed write data.
- req_grant  out  NUM_REQ  one-hot accept strobe (combinational).
- ram_wr_en  out  1  registered RAM write enable.
- ram_addr  out  MAX_POSITIONS_LOG2  registered RAM address.
- ram_wr_data  out  RAM_WIDTH  registered RAM write data.
- ram_rd_data  in  RAM_WIDTH  RAM read data.
- rsp_valid  out  1  read data valid.
- rsp_id  out  ID_W  requester ID for rsp_data.
- rsp_data  out  RAM_WIDTH  read data, equal to ram_rd_data.
- busy  out  1  a read is in flight or a request is pending.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: ram_wr_en=0, ram_addr=0, ram_wr_data=0, rsp_valid=0, rsp_id=0, and the round-robin pointer = NUM_REQ-1, so requester 0 wins first.
- Handshake:
  - A requester holds req_valid, req_wr, req_addr and req_wr_data stable until req_grant[i]=1 in the same cycle; the transfer completes on that clock edge.
  - req_grant is at most one-hot and is zero while reset is high.
- Arbitration:
  - Round-robin search begins at (last granted + 1) mod NUM_REQ.
  - The pointer updates only on a grant.
  - Reads and writes are arbitrated identically.
  - A requester may re-request on the cycle after its grant; it is then lowest priority.
- Pipeline, for a grant in cycle T:
  - ram_addr, ram_wr_en and ram_wr_data are valid in cycle T+1.
  - For a read, rsp_valid=1 with the matching rsp_id in cycle T+1+RD_LATENCY (T+3 at default).
  - A write generates no response.
  - A delay line of depth 1+RD_LATENCY carries {valid, id}.
- Cycles with no grant drive ram_wr_en=0. ram_addr holds its previous value.
- Throughput is one access per cycle. Responses return in grant order; back-to-back reads give back-to-back rsp_valid.
- Ordering:
  - Write granted at T followed by a read of the same address granted at T+1 or later: the read returns the new data.
  - Read granted at T followed by a write granted at T+1 to the same address: the read returns the old data.
- busy = |req_valid OR any delay-line valid.
- Reset mid-operation clears the delay line; no rsp_valid appears after reset, even for reads granted before it.
- NUM_REQ=1 degenerates to a registered pass-through; ID_W becomes max(1, clog2).

Optional Feature:
- MRAM_ARB_STATS_EN defined: adds input stats_clear (1) and output grant_count (NUM_REQ*32).
  - Each per-requester counter increments on its grant and saturates at 32'hFFFFFFFF.
  - Counters are cleared by reset or by stats_clear; clear wins over a same-cycle grant.
- MRAM_ARB_STATS_EN undefined: neither port exists and no counter logic is built.

Decomposition:
- vchess.vh keeps `MAX_POSITIONS.
- Add a shared constant MRAM_RD_LATENCY=2 so this block and the position RAM agree on latency.
- Natural sub-module: rr_arbiter (request vector and pointer in; one-hot grant and encoded index out), reusable by other shared-resource controllers.

Test Plan:
- Reset, then req_valid=4'b1111, all reads to addresses 10,11,12,13 -> grants in order 0,1,2,3 on consecutive cycles; rsp_id 0,1,2,3 on cycles T+3..T+6, each with the data preloaded at its address.
- Req 2 writes 0xDEAD to addr 5 (grant T); req 0 reads addr 5 (grant T+1) -> rsp_id=0, rsp_data=0xDEAD at T+4.
- Req 1 reads addr 7 holding 0x1 (grant T); req 3 writes 0x2 to addr 7 at T+1 -> read returns 0x1 at T+3; a later read returns 0x2.
- Req 0 requesting continuously while req 1 requests -> grants alternate 0,1,0,1; no starvation over 100 cycles.
- Issue 3 reads, assert reset one cycle after the last grant -> rsp_valid stays 0 throughout and after reset; the first post-reset grant goes to requester 0.
- With MRAM_ARB_STATS_EN: 5 grants to req 2, then stats_clear asserted in the same cycle as a 6th grant -> grant_count slice 2 = 0.

Source files
------------

// File: rtl/mram_port_arb_pkg.sv
// Shared constants and types for the position-RAM port arbiter.
// MRAM_RD_LATENCY is the single source of truth for RAM read latency.
`ifndef MAX_POSITIONS
`define MAX_POSITIONS 1024
`endif

package mram_port_arb_pkg;
  localparam int MRAM_RD_LATENCY = 2;
  localparam int MRAM_ADDR_W     = $clog2(`MAX_POSITIONS);

  typedef enum logic {
    ACC_RD = 1'b0,
    ACC_WR = 1'b1
  } acc_e;

  // Requester ID width; a single requester still needs one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mram_port_arb_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past ptr and
// wraps, so the requester at ptr has the lowest priority.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);
  always_comb begin
    int unsigned k;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    k       = 0;
    for (int i = 1; i <= N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!gnt_any && req[IW'(k)]) begin
        gnt_any         = 1'b1;
        gnt[IW'(k)]     = 1'b1;
        gnt_idx         = IW'(k);
      end
    end
  end
endmodule

// File: rtl/mram_port_arb.sv
// Round-robin sharing of one position-RAM port with tagged read returns.
// Define MRAM_ARB_STATS_EN to add per-requester grant counters.
module mram_port_arb
  import mram_port_arb_pkg::*;
#(
  parameter int NUM_REQ            = 4,
  parameter int RAM_WIDTH          = 64,
  parameter int MAX_POSITIONS_LOG2 = MRAM_ADDR_W,
  parameter int RD_LATENCY         = MRAM_RD_LATENCY,
  parameter int ID_W               = id_width(NUM_REQ)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ-1:0]                    req_wr,
  input  logic [NUM_REQ*MAX_POSITIONS_LOG2-1:0] req_addr,
  input  logic [NUM_REQ*RAM_WIDTH-1:0]          req_wr_data,
  output logic [NUM_REQ-1:0]                    req_grant,
  output logic                                  ram_wr_en,
  output logic [MAX_POSITIONS_LOG2-1:0]         ram_addr,
  output logic [RAM_WIDTH-1:0]                  ram_wr_data,
  input  logic [RAM_WIDTH-1:0]                  ram_rd_data,
  output logic                                  rsp_valid,
  output logic [ID_W-1:0]                       rsp_id,
  output logic [RAM_WIDTH-1:0]                  rsp_data,
`ifdef MRAM_ARB_STATS_EN
  input  logic                                  stats_clear,
  output logic [NUM_REQ*32-1:0]                 grant_count,
`endif
  output logic                                  busy
);
  localparam int DEPTH = 1 + RD_LATENCY;
  localparam int AW    = MAX_POSITIONS_LOG2;

  logic [NUM_REQ-1:0]             gnt;
  logic [ID_W-1:0]                gnt_idx;
  logic                           gnt_any, take;
  acc_e                           gnt_kind;
  logic [ID_W-1:0]                ptr_q, ptr_d;
  logic                           wr_en_q, wr_en_d;
  logic [AW-1:0]                  addr_q, addr_d;
  logic [RAM_WIDTH-1:0]           wdata_q, wdata_d;
  logic [DEPTH-1:0]               vld_pipe_q, vld_pipe_d;
  logic [DEPTH-1:0][ID_W-1:0]     id_pipe_q, id_pipe_d;

  rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_rr (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign take      = gnt_any & ~reset;
  assign req_grant = reset ? '0 : gnt;
  assign gnt_kind  = acc_e'(req_wr[gnt_idx]);

  always_comb begin
    ptr_d         = take ? gnt_idx : ptr_q;
    wr_en_d       = take && (gnt_kind == ACC_WR);
    addr_d        = take ? req_addr[gnt_idx*AW +: AW] : addr_q;
    wdata_d       = take ? req_wr_data[gnt_idx*RAM_WIDTH +: RAM_WIDTH] : wdata_q;
    // Only reads travel down the delay line; writes produce no response.
    vld_pipe_d    = {vld_pipe_q[DEPTH-2:0], take && (gnt_kind == ACC_RD)};
    id_pipe_d     = id_pipe_q;
    id_pipe_d[0]  = gnt_idx;
    for (int s = 1; s < DEPTH; s++) id_pipe_d[s] = id_pipe_q[s-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q      <= ID_W'(NUM_REQ - 1);
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      vld_pipe_q <= '0;
      id_pipe_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      vld_pipe_q <= vld_pipe_d;
      id_pipe_q  <= id_pipe_d;
    end
  end

  assign ram_wr_en   = wr_en_q;
  assign ram_addr    = addr_q;
  assign ram_wr_data = wdata_q;
  // Gated so that reads issued before a reset never surface.
  assign rsp_valid   = vld_pipe_q[DEPTH-1] & ~reset;
  assign rsp_id      = id_pipe_q[DEPTH-1];
  assign rsp_data    = ram_rd_data;
  assign busy        = (|req_valid) | (|vld_pipe_q);

`ifdef MRAM_ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0] cnt_q, cnt_d;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (stats_clear)                               cnt_d[i] = '0;
      else if (req_grant[i] && (cnt_q[i] != '1))     cnt_d[i] = cnt_q[i] + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign grant_count = cnt_q;
`endif
endmodule
